// File: rtl/fir_tap_loader_if.sv
// rtl/fir_tap_loader_if.sv - host/tap-chain signal bundle for fir_tap_loader
// Purpose: groups the load control, the coefficient beat stream and the
//          tap-chain shift port so they travel as one port.
// Signals:
//   i_start      load request              (host -> loader)
//   i_abort      cancel an in-progress load (host -> loader)
//   i_coef_valid coefficient beat valid     (host -> loader)
//   i_coef       coefficient beat data      (host -> loader)
//   o_coef_ready loader accepts a beat      (loader -> host)
//   o_tap_wr     tap-chain shift enable     (loader -> FIR)
//   o_tap        coefficient to shift in    (loader -> FIR)
//   o_busy       load in progress           (loader -> host)
//   o_done       one-cycle completion pulse (loader -> host)
interface fir_tap_loader_if #(
    parameter int TW = 12
);
    logic          i_start;
    logic          i_abort;
    logic          i_coef_valid;
    logic [TW-1:0] i_coef;
    logic          o_coef_ready;
    logic          o_tap_wr;
    logic [TW-1:0] o_tap;
    logic          o_busy;
    logic          o_done;

    modport master (
        output i_start, i_abort, i_coef_valid, i_coef,
        input  o_coef_ready, o_tap_wr, o_tap, o_busy, o_done
    );

    modport slave (
        input  i_start, i_abort, i_coef_valid, i_coef,
        output o_coef_ready, o_tap_wr, o_tap, o_busy, o_done
    );
endinterface

// File: rtl/fir_tap_loader.sv
// rtl/fir_tap_loader.sv - shadow-buffered FIR coefficient loader
// Purpose: collects N coefficient beats into a shadow buffer, then shifts
//          them into the FIR tap chain in arrival order, one per cycle.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    fir_tap_loader_if.slave (control, coefficient stream, tap port)
module fir_tap_loader #(
    parameter int N  = 32,
    parameter int TW = 12
) (
    input  logic                clk,
    input  logic                reset,
    fir_tap_loader_if.slave     bus
);
    localparam int CW = $clog2(N + 1);
    localparam int IW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] shadow_q [N];
    logic          shadow_we;
    logic [IW-1:0] idx;

    // cnt never exceeds N-1 while it is used as an index.
    assign idx = cnt_q[IW-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Shadow contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk) begin
        if (shadow_we) begin
            shadow_q[idx] <= bus.i_coef;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shadow_we = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.i_start && !bus.i_abort) begin
                    state_d = S_FILL;
                    cnt_d   = '0;
                end
            end
            S_FILL: begin
                if (bus.i_abort) begin
                    // Abort beats a simultaneous beat: nothing is written.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (bus.i_coef_valid) begin
                    shadow_we = 1'b1;
                    if (cnt_q == LAST) begin
                        // Buffer full: the counter is reused as the shift
                        // index, so restart it for shift cycle 0.
                        state_d = S_SHIFT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_SHIFT: begin
                if (bus.i_abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode the registered state only, so reset clears them
    // without waiting for a clock edge.
    assign bus.o_coef_ready = (state_q == S_FILL);
    assign bus.o_tap_wr     = (state_q == S_SHIFT);
    assign bus.o_tap        = (state_q == S_SHIFT) ? shadow_q[idx] : '0;
    assign bus.o_busy       = (state_q == S_FILL) || (state_q == S_SHIFT);
    assign bus.o_done       = (state_q == S_DONE);
endmodule

// File: doc/fir_tap_loader.md
FIR_TAP_LOADER -- requirements
Module: fir_tap_loader

Interface
REQ-001 The module SHALL have parameter N, default 32, number of filter taps (N >= 2).
REQ-002 The module SHALL have parameter TW, default 12, tap coefficient width in bits.
REQ-003 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port i_start  input  1  request a new coefficient load; sampled only in IDLE.
REQ-006 Port i_abort  input  1  cancel an in-progress load.
REQ-007 Port i_coef_valid  input  1  host coefficient beat valid.
REQ-008 Port i_coef  input  TW  host coefficient data.
REQ-009 Port o_coef_ready  output  1  loader accepts a coefficient beat.
REQ-010 Port o_tap_wr  output  1  shift-enable to the FIR tap chain.
REQ-011 Port o_tap  output  TW  coefficient presented to the FIR tap chain.
REQ-012 Port o_busy  output  1  high while in FILL or SHIFT.
REQ-013 Port o_done  output  1  one-cycle pulse when a load completes.

Function
REQ-014 The block SHALL implement the states IDLE, FILL, SHIFT and DONE, with a shadow buffer of N entries of TW bits each.
REQ-015 In IDLE, i_start=1 SHALL move the block to FILL on the next edge and clear the beat counter to 0.
REQ-016 In FILL, o_coef_ready SHALL be 1. Each cycle with i_coef_valid=1 and o_coef_ready=1 SHALL write i_coef into buffer[cnt] and increment cnt.
REQ-017 The beat that brings cnt to N SHALL move the block to SHIFT on the same edge. o_coef_ready SHALL be 0 from that edge onward.
REQ-018 i_coef_valid=1 outside FILL SHALL be ignored: no write, and o_coef_ready=0.
REQ-019 In SHIFT, o_tap_wr SHALL be 1 for exactly N consecutive cycles.
REQ-020 On shift cycle k (k = 0..N-1), o_tap SHALL equal buffer[k], so the first coefficient received is the first one shifted in.
REQ-021 o_tap SHALL be 0 whenever o_tap_wr=0.
REQ-022 After the N-th shift cycle, the block SHALL enter DONE for exactly one cycle with o_done=1, then return to IDLE.
REQ-023 i_start while not in IDLE SHALL be ignored.
REQ-024 i_abort=1 in FILL or SHIFT SHALL return the block to IDLE on the next edge, with o_tap_wr=0, o_done=0 and cnt cleared. The remaining shifts SHALL NOT be issued.
REQ-025 i_abort=1 in IDLE or DONE SHALL have no effect.
REQ-026 If i_abort and an accepting beat occur in the same cycle, abort SHALL win and the beat SHALL be discarded.
REQ-027 If i_start and i_abort are both 1 in IDLE, the block SHALL stay in IDLE.
REQ-028 The latency from the accepting edge of the N-th beat to the first cycle with o_tap_wr=1 SHALL be 0 cycles: o_tap_wr is asserted in the first SHIFT cycle.
REQ-029 The buffer SHALL be overwritten only in FILL. Stale contents SHALL never reach o_tap without a complete FILL first.
REQ-030 The counter SHALL be wide enough to hold N (clog2(N+1) bits) and SHALL NOT wrap during FILL or SHIFT.

Reset
REQ-031 While reset=0, the block SHALL be in IDLE with o_coef_ready=0, o_tap_wr=0, o_tap=0, o_busy=0, o_done=0 and cnt=0. This SHALL apply immediately, regardless of clk.
REQ-032 Reset asserted mid-FILL or mid-SHIFT SHALL deassert o_tap_wr asynchronously. The buffer contents are don't-care after reset.
REQ-033 After reset deasserts, the block SHALL stay in IDLE until i_start=1.

Verification
REQ-034 N=4, TW=12: i_start, then beats 0x001, 0x002, 0x003, 0x004 back-to-back -> o_tap_wr=1 for 4 cycles with o_tap 0x001, 0x002, 0x003, 0x004, then o_done=1 for 1 cycle, then IDLE.
REQ-035 N=4, TW=12: beats gapped by idle cycles and valid=1 held during SHIFT -> exactly 4 writes; beats during SHIFT are not accepted (o_coef_ready=0).
REQ-036 N=4, TW=12: abort after 2 beats -> IDLE next cycle, no o_tap_wr pulse, no o_done. A following full load shifts only the new 4 values.
REQ-037 N=4, TW=12: abort on the 2nd SHIFT cycle -> o_tap_wr drops the next cycle, only 2 writes issued, o_done never asserts.
REQ-038 N=4, TW=12: reset=0 asserted during SHIFT -> o_tap_wr=0 and o_tap=0 without a clock edge. After release, i_start pulses during SHIFT of a new load are ignored.
REQ-039 N=4, TW=12: i_start and i_abort together in IDLE -> stays IDLE and o_coef_ready stays 0.
